// File: rtl/fifo32_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the 32-entry pointer/flag controller.
// The master side issues push/pop requests; the slave side is the controller.
interface fifo32_ctrl_if;
  logic       WrEn;
  logic       RdEn;
  logic       RamWe;
  logic [4:0] WrAddr;
  logic [4:0] RdAddr;
  logic       Full;
  logic       Empty;
  logic       AlmostFull;
  logic       AlmostEmpty;
  logic [5:0] Count;
  logic       Overflow;
  logic       Underflow;

  modport master (
    output WrEn, RdEn,
    input  RamWe, WrAddr, RdAddr, Full, Empty, AlmostFull, AlmostEmpty,
           Count, Overflow, Underflow
  );

  modport slave (
    input  WrEn, RdEn,
    output RamWe, WrAddr, RdAddr, Full, Empty, AlmostFull, AlmostEmpty,
           Count, Overflow, Underflow
  );
endinterface

// File: rtl/fifo32_ctrl.sv
// Pointer/flag controller for a 32x8 FIFO RAM: write strobe, addresses, occupancy and flags.
// Holds no data; the RAM writes at WrAddr on the same edge RamWe is high.
module fifo32_ctrl #(
  parameter int unsigned AF_LEVEL = 28,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fifo32_ctrl_if.slave  bus
);

  localparam logic [5:0] AF_THRESH = 6'(AF_LEVEL);
  localparam logic [5:0] AE_THRESH = 6'(AE_LEVEL);

  logic [5:0] r_wrPtr;
  logic [5:0] r_rdPtr;
  logic [5:0] r_count;
  logic       r_overflow;
  logic       r_underflow;

  logic       w_full;
  logic       w_empty;
  logic       w_pushOk;
  logic       w_popOk;

  // Bit 5 is the wrap bit: equal addresses with differing wrap bits means 32 entries held.
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[4:0] == r_rdPtr[4:0]) && (r_wrPtr[5] != r_rdPtr[5]);
  assign w_pushOk = bus.WrEn && !w_full;
  assign w_popOk  = bus.RdEn && !w_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wrPtr     <= 6'd0;
      r_rdPtr     <= 6'd0;
      r_count     <= 6'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 6'd1;
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + 6'd1;
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 6'd1;
        2'b01:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
      if (bus.WrEn && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.RdEn && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Strobe is gated by reset so a push held across reset never reaches the RAM.
  assign bus.RamWe       = w_pushOk && i_rst_n;
  assign bus.WrAddr      = r_wrPtr[4:0];
  assign bus.RdAddr      = r_rdPtr[4:0];
  assign bus.Full        = w_full;
  assign bus.Empty       = w_empty;
  assign bus.Count       = r_count;
  assign bus.AlmostFull  = (r_count >= AF_THRESH);
  assign bus.AlmostEmpty = (r_count <= AE_THRESH);
  assign bus.Overflow    = r_overflow;
  assign bus.Underflow   = r_underflow;

endmodule

// File: tb/tb_fifo32_ctrl.sv
// Self-checking bench for fifo32_ctrl: occupancy model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo32_ctrl;

  logic clk;
  logic rst_n;

  int compareCount = 0;
  int failCount    = 0;

  // Model state: totals of accepted pushes/pops since reset, and sticky errors.
  int   mPushes = 0;
  int   mPops   = 0;
  logic mOver   = 1'b0;
  logic mUnder  = 1'b0;
  logic mValid  = 1'b0;

  fifo32_ctrl_if bus();

  fifo32_ctrl #(.AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compareCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update: occupancy is pushes minus pops, and requests are accepted by occupancy alone.
  always @(posedge clk) begin
    int occ;
    occ = mPushes - mPops;
    if (!rst_n) begin
      mPushes <= 0;
      mPops   <= 0;
      mOver   <= 1'b0;
      mUnder  <= 1'b0;
      mValid  <= 1'b1;
    end else if (mValid) begin
      if (bus.WrEn && occ == 32) mOver <= 1'b1;
      if (bus.RdEn && occ == 0)  mUnder <= 1'b1;
      if (bus.WrEn && occ < 32)  mPushes <= mPushes + 1;
      if (bus.RdEn && occ > 0)   mPops <= mPops + 1;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    int occ;
    occ = mPushes - mPops;
    if (mValid) begin
      checkOutput("mdl_RamWe", int'(bus.RamWe), int'(bus.WrEn && rst_n && occ < 32));
      checkOutput("mdl_WrAddr", int'(bus.WrAddr), mPushes % 32);
      checkOutput("mdl_RdAddr", int'(bus.RdAddr), mPops % 32);
      checkOutput("mdl_Count", int'(bus.Count), occ);
      checkOutput("mdl_Full", int'(bus.Full), int'(occ == 32));
      checkOutput("mdl_Empty", int'(bus.Empty), int'(occ == 0));
      checkOutput("mdl_AlmostFull", int'(bus.AlmostFull), int'(occ >= 28));
      checkOutput("mdl_AlmostEmpty", int'(bus.AlmostEmpty), int'(occ <= 4));
      checkOutput("mdl_Overflow", int'(bus.Overflow), int'(mOver));
      checkOutput("mdl_Underflow", int'(bus.Underflow), int'(mUnder));
    end
  end

  // Hold the given inputs for n rising edges, then return to idle shortly after the last edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic rstn, input int n);
    bus.WrEn = wr;
    bus.RdEn = rd;
    rst_n    = rstn;
    repeat (n) @(posedge clk);
    #1;
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
    rst_n    = 1'b1;
    #1;
  endtask

  initial begin
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
    rst_n    = 1'b0;
    #2;

    // Reset then idle.
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    checkOutput("rst_Empty", int'(bus.Empty), 1);
    checkOutput("rst_Full", int'(bus.Full), 0);
    checkOutput("rst_Count", int'(bus.Count), 0);
    checkOutput("rst_WrAddr", int'(bus.WrAddr), 0);
    checkOutput("rst_RdAddr", int'(bus.RdAddr), 0);
    checkOutput("rst_RamWe", int'(bus.RamWe), 0);
    checkOutput("rst_Overflow", int'(bus.Overflow), 0);
    checkOutput("rst_Underflow", int'(bus.Underflow), 0);
    checkOutput("rst_AlmostEmpty", int'(bus.AlmostEmpty), 1);

    // Fill, watching the AlmostFull threshold.
    applyStimulus(1'b1, 1'b0, 1'b1, 27);
    checkOutput("fill27_AlmostFull", int'(bus.AlmostFull), 0);
    checkOutput("fill27_Count", int'(bus.Count), 27);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("fill28_AlmostFull", int'(bus.AlmostFull), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4);
    checkOutput("fill32_Full", int'(bus.Full), 1);
    checkOutput("fill32_Count", int'(bus.Count), 32);
    checkOutput("fill32_WrAddr", int'(bus.WrAddr), 0);

    // Push while full: rejected, Overflow sticks.
    bus.WrEn = 1'b1;
    #1;
    checkOutput("ovf_RamWe", int'(bus.RamWe), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("ovf_Overflow", int'(bus.Overflow), 1);
    checkOutput("ovf_WrAddr", int'(bus.WrAddr), 0);
    checkOutput("ovf_Count", int'(bus.Count), 32);

    // Drain.
    applyStimulus(1'b0, 1'b1, 1'b1, 32);
    checkOutput("drain_Empty", int'(bus.Empty), 1);
    checkOutput("drain_Count", int'(bus.Count), 0);
    checkOutput("drain_RdAddr", int'(bus.RdAddr), 0);
    checkOutput("drain_Overflow", int'(bus.Overflow), 1);

    // Pop on empty, then push+pop on empty.
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("udf_Underflow", int'(bus.Underflow), 1);
    checkOutput("udf_RdAddr", int'(bus.RdAddr), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("both_empty_Count", int'(bus.Count), 1);
    checkOutput("both_empty_RdAddr", int'(bus.RdAddr), 0);
    checkOutput("both_empty_WrAddr", int'(bus.WrAddr), 1);

    // Fresh start, fill to 20, then steady-state push+pop across the wrap.
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4);
    checkOutput("fill4_AlmostEmpty", int'(bus.AlmostEmpty), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("fill5_AlmostEmpty", int'(bus.AlmostEmpty), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 15);
    checkOutput("fill20_Count", int'(bus.Count), 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 50);
    checkOutput("stream_Count", int'(bus.Count), 20);
    checkOutput("stream_WrAddr", int'(bus.WrAddr), 6);
    checkOutput("stream_RdAddr", int'(bus.RdAddr), 18);

    // Reset mid-operation with a push pending.
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 10);
    checkOutput("fill10_Count", int'(bus.Count), 10);
    bus.WrEn = 1'b1;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_RamWe", int'(bus.RamWe), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("midrst_Count", int'(bus.Count), 0);
    checkOutput("midrst_Empty", int'(bus.Empty), 1);
    checkOutput("midrst_WrAddr", int'(bus.WrAddr), 0);
    checkOutput("midrst_RdAddr", int'(bus.RdAddr), 0);
    checkOutput("midrst_Overflow", int'(bus.Overflow), 0);
    checkOutput("midrst_Underflow", int'(bus.Underflow), 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
